axil_wb_master: RTL and testbench
=================================

// Module: axil_wb_master
// PURPOSE
//  AXI4-Lite slave to Wishbone master bridge: the opposite direction of the Caravel user-project WB-slave/AXI-master path.
//  Accepts single-beat AXI-Lite reads/writes, e.g. from a DMA or test controller. Issues one Wishbone classic cycle per AXI transaction.
//  Wishbone address = BASE_ADDR + AXI address. Returns the response on the B or R channel.
//  A watchdog ends stalled WB cycles with SLVERR.
// PARAMETERS
//  pADDR_WIDTH  12            AXI-Lite address width; zero-extended to 32 bits before the BASE_ADDR add
//  pDATA_WIDTH  32            data width (AXI and WB)
//  BASE_ADDR    32'h3000_0000 WB window base (user-project area)
//  TIMEOUT      16            WB cycles without ack before abort (>=2)
// PORTS
//  wb_clk_i   in  1   clock, all logic on rising edge
//  wb_rst_i   in  1   reset, synchronous, active-high
//  awvalid/awready  in/out 1        write-address handshake
//  awaddr           in  pADDR_WIDTH write address
//  wvalid/wready    in/out 1        write-data handshake
//  wdata            in  pDATA_WIDTH write data
//  bvalid/bready    out/in 1        write response handshake; bresp out 2 (00 OKAY, 10 SLVERR)
//  arvalid/arready  in/out 1        read-address handshake
//  araddr           in  pADDR_WIDTH read address
//  rvalid/rready    out/in 1        read-data handshake
//  rdata            out pDATA_WIDTH read data; rresp out 2 (00 OKAY, 10 SLVERR)
//  wbm_cyc_o, wbm_stb_o, wbm_we_o  out 1  WB cycle, strobe, write enable
//  wbm_sel_o  out 4   byte selects, always 4'hF during a cycle
//  wbm_adr_o  out 32  WB address;  wbm_dat_o out 32 WB write data
//  wbm_dat_i  in  32  WB read data; wbm_ack_i in 1 WB acknowledge
// BEHAVIOUR
//  - Reset values: all *ready, bvalid, rvalid, wbm_cyc/stb/we = 0; sel, adr, dat_o, rdata = 0; bresp, rresp = 2'b00. FSM -> IDLE.
//    Reset mid-transaction drops the WB cycle on the next edge; no response is issued.
//  - FSM states: IDLE, WB_WR, B_RESP, WB_RD, R_RESP.
//  - IDLE, write path:
//      awready = !aw_held; wready = !w_held.
//      AW and W are accepted independently, in any order, and captured into holding regs (aw_held, w_held).
//      When both are held, or complete on this edge, -> WB_WR.
//  - IDLE, read path:
//      arready = !(aw_held|w_held|awvalid|wvalid). Writes always win and reads are blocked while any write is pending.
//      AR handshake -> WB_RD.
//  - WB_WR / WB_RD: cyc = stb = 1, sel = 4'hF, we = 1 (WR) or 0 (RD); adr and dat_o are registered and stable for the whole cycle.
//    Timing from handshake edge T: cyc is high during T+1.
//  - wbm_ack_i is sampled while cyc is high. On ack:
//      cyc/stb/we drop on the next edge.
//      WR -> B_RESP with bresp = OKAY.
//      RD -> R_RESP with rdata <= wbm_dat_i, rresp = OKAY.
//    Single-cycle ack gives bvalid/rvalid in cycle T+2.
//  - Watchdog: counter clears on WB-cycle entry and increments each cycle without ack.
//    At TIMEOUT it aborts: cyc drops, WR -> bresp = SLVERR, RD -> rdata = 32'hDEAD_BEEF and rresp = SLVERR.
//    If ack arrives in the same cycle as the timeout, ack wins (OKAY).
//  - B_RESP: bvalid is held until bready. On the handshake, clear aw_held/w_held -> IDLE.
//  - R_RESP: rvalid is held and rdata is stable until rready -> IDLE.
//  - No new AXI handshake (all ready = 0) outside IDLE, so at most one transaction is outstanding.
//  - Address: wbm_adr_o = BASE_ADDR + {zero-ext addr}, 32-bit add with wrap; no alignment check.
// STRUCTURE
//  - Shared package wb_axi_pkg: FSM state localparams (3-bit), RESP_OKAY/RESP_SLVERR, the TIMEOUT_DATA constant 32'hDEAD_BEEF.
//  - One sub-module: wb_watchdog. Inputs clr, en, ack; output expired. Counter width = $clog2(TIMEOUT+1).
//  - Everything else sits in the top: FSM, holding regs, output regs.
// TESTING
//  1 AW+W same cycle: awaddr 12'h010, wdata 32'h1234_5678, ack on first stb
//    -> cyc at T+1, adr 32'h3000_0010, dat_o 32'h1234_5678, bvalid at T+2, bresp 00.
//  2 W 3 cycles before AW (addr 12'h084)
//    -> no cyc until the AW handshake. One WB write to 32'h3000_0084. awready is low again until B completes.
//  3 Read 12'h000, ack after 3 wait states with wbm_dat_i 32'h0000_0006
//    -> rvalid with rdata 32'h6, rresp 00. rdata holds while rready is low for 4 cycles.
//  4 AR and AW+W asserted together -> write done first (bvalid), then the read (rvalid). Exactly two WB cycles.
//  5 Never ack a read -> cyc drops after 16 cycles; rdata 32'hDEAD_BEEF, rresp 10. The next transaction completes normally.
//  6 wb_rst_i pulsed while in WB_WR -> cyc/stb = 0 next cycle, no bvalid, and all outputs at reset values.

Source files
------------

// File: rtl/wb_axi_pkg.sv
// Shared types and constants for the AXI4-Lite slave to Wishbone master bridge.
package wb_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WB_WR  = 3'd1,
      ST_B_RESP = 3'd2,
      ST_WB_RD  = 3'd3,
      ST_R_RESP = 3'd4
   } state_e;

   localparam logic [1:0]  RESP_OKAY    = 2'b00;
   localparam logic [1:0]  RESP_SLVERR  = 2'b10;
   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   // Window translation: 32-bit add that wraps, no alignment check.
   function automatic logic [31:0] wb_addr(input logic [31:0] base, input logic [31:0] offs);
      return base + offs;
   endfunction

endpackage

// File: rtl/axil_wb_master_if.sv
// Bus bundles used by the bridge: an AXI4-Lite link and a Wishbone classic link.
interface axil_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
   logic              bvalid;
   logic              bready;
   logic [1:0]        bresp;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport slave (
      input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

interface wb_if #(
   parameter int DATA_W = 32
);
   logic              wbm_cyc_o;
   logic              wbm_stb_o;
   logic              wbm_we_o;
   logic [3:0]        wbm_sel_o;
   logic [31:0]       wbm_adr_o;
   logic [DATA_W-1:0] wbm_dat_o;
   logic [DATA_W-1:0] wbm_dat_i;
   logic              wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );
   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/wb_watchdog.sv
// Counts Wishbone cycles without acknowledge; flags the last allowed cycle.
module wb_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   input  logic ack_i,
   output logic expired_o
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // The count equals the number of unacknowledged cycles so far, so the
   // flag is raised during the TIMEOUT-th cycle and the abort lands on its edge.
   assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

   // Next count: clear outside a cycle, step on every cycle that lacks an ack.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !ack_i && !expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/axil_wb_master.sv
// AXI4-Lite slave to Wishbone classic master bridge, one transaction in flight.
module axil_wb_master #(
   parameter int          pADDR_WIDTH = 12,
   parameter int          pDATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          TIMEOUT     = 16
) (
   input  logic   wb_clk_i,
   input  logic   wb_rst_i,
   axil_if.slave  axi,
   wb_if.master   wb
);
   import wb_axi_pkg::*;

   state_e                 state_q, state_d;
   logic                   aw_held_q, aw_held_d;
   logic                   w_held_q, w_held_d;
   logic                   cyc_q, cyc_d;
   logic                   we_q, we_d;
   logic [3:0]             sel_q, sel_d;
   logic [31:0]            adr_q, adr_d;
   logic [pDATA_WIDTH-1:0] dat_q, dat_d;
   logic                   bvalid_q, bvalid_d;
   logic [1:0]             bresp_q, bresp_d;
   logic                   rvalid_q, rvalid_d;
   logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]             rresp_q, rresp_d;

   logic        idle_s, awready_s, wready_s, arready_s;
   logic        aw_hs_s, w_hs_s, ar_hs_s, ack_s, expired_s;
   logic [31:0] awaddr_ext_s, araddr_ext_s;

   // Readies are only offered in IDLE and stay low while reset is asserted.
   // Any pending or offered write blocks the read channel.
   assign idle_s    = (state_q == ST_IDLE) && !wb_rst_i;
   assign awready_s = idle_s && !aw_held_q;
   assign wready_s  = idle_s && !w_held_q;
   assign arready_s = idle_s && !(aw_held_q || w_held_q || axi.awvalid || axi.wvalid);
   assign aw_hs_s   = axi.awvalid && awready_s;
   assign w_hs_s    = axi.wvalid && wready_s;
   assign ar_hs_s   = axi.arvalid && arready_s;
   assign ack_s     = cyc_q && wb.wbm_ack_i;

   assign awaddr_ext_s = {{(32 - pADDR_WIDTH){1'b0}}, axi.awaddr};
   assign araddr_ext_s = {{(32 - pADDR_WIDTH){1'b0}}, axi.araddr};

   wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .clr_i     (state_q == ST_IDLE),
      .en_i      (cyc_q),
      .ack_i     (ack_s),
      .expired_o (expired_s)
   );

   assign axi.awready  = awready_s;
   assign axi.wready   = wready_s;
   assign axi.arready  = arready_s;
   assign axi.bvalid   = bvalid_q;
   assign axi.bresp    = bresp_q;
   assign axi.rvalid   = rvalid_q;
   assign axi.rdata    = rdata_q;
   assign axi.rresp    = rresp_q;
   assign wb.wbm_cyc_o = cyc_q;
   assign wb.wbm_stb_o = cyc_q;
   assign wb.wbm_we_o  = we_q;
   assign wb.wbm_sel_o = sel_q;
   assign wb.wbm_adr_o = adr_q;
   assign wb.wbm_dat_o = dat_q;

   // Next state and next output values; ack takes priority over the watchdog.
   always_comb begin
      state_d   = state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (state_q)
         ST_IDLE: begin
            // The address register doubles as the AW holding register.
            if (aw_hs_s) begin
               aw_held_d = 1'b1;
               adr_d     = wb_addr(BASE_ADDR, awaddr_ext_s);
            end else if (ar_hs_s) begin
               adr_d = wb_addr(BASE_ADDR, araddr_ext_s);
            end else begin
               adr_d = adr_q;
            end
            if (w_hs_s) begin
               w_held_d = 1'b1;
               dat_d    = axi.wdata;
            end else begin
               dat_d = dat_q;
            end
            if ((aw_held_q || aw_hs_s) && (w_held_q || w_hs_s)) begin
               state_d = ST_WB_WR;
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               sel_d   = 4'hF;
            end else if (ar_hs_s) begin
               state_d = ST_WB_RD;
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               sel_d   = 4'hF;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WB_WR: begin
            if (ack_s || expired_s) begin
               state_d  = ST_B_RESP;
               cyc_d    = 1'b0;
               we_d     = 1'b0;
               sel_d    = 4'h0;
               bvalid_d = 1'b1;
               bresp_d  = ack_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
               state_d = ST_WB_WR;
            end
         end
         ST_WB_RD: begin
            if (ack_s) begin
               state_d  = ST_R_RESP;
               cyc_d    = 1'b0;
               sel_d    = 4'h0;
               rvalid_d = 1'b1;
               rdata_d  = wb.wbm_dat_i;
               rresp_d  = RESP_OKAY;
            end else if (expired_s) begin
               state_d  = ST_R_RESP;
               cyc_d    = 1'b0;
               sel_d    = 4'h0;
               rvalid_d = 1'b1;
               rdata_d  = TIMEOUT_DATA;
               rresp_d  = RESP_SLVERR;
            end else begin
               state_d = ST_WB_RD;
            end
         end
         ST_B_RESP: begin
            if (axi.bready) begin
               state_d   = ST_IDLE;
               bvalid_d  = 1'b0;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
            end else begin
               state_d = ST_B_RESP;
            end
         end
         ST_R_RESP: begin
            if (axi.rready) begin
               state_d  = ST_IDLE;
               rvalid_d = 1'b0;
            end else begin
               state_d = ST_R_RESP;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            cyc_d     = 1'b0;
            we_d      = 1'b0;
            sel_d     = 4'h0;
            bvalid_d  = 1'b0;
            rvalid_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any cycle without a response.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= ST_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 4'h0;
         adr_q     <= 32'h0;
         dat_q     <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end
endmodule

// File: tb/tb_axil_wb_master.sv
// Scoreboard bench for axil_wb_master: AXI master tasks plus a Wishbone slave model.
module tb_axil_wb_master;

   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
   } wb_exp_t;

   typedef struct {
      bit          is_rd;
      logic [1:0]  resp;
      logic [31:0] data;
   } resp_exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axil_if #(.ADDR_W(12), .DATA_W(32)) axi();
   wb_if   #(.DATA_W(32))              wb();

   axil_wb_master #(
      .pADDR_WIDTH (12),
      .pDATA_WIDTH (32),
      .BASE_ADDR   (32'h3000_0000),
      .TIMEOUT     (16)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .axi      (axi),
      .wb       (wb)
   );

   int          checks_cnt = 0;
   int          errors_cnt = 0;
   wb_exp_t     wbq[$];
   resp_exp_t   respq[$];
   int          wait_states = 0;
   bit          ack_en = 1'b1;
   logic [31:0] rd_word = 32'h0;
   int          wb_cycles = 0;
   int          last_cyc_len = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_adr(input logic [11:0] a);
      return BASE + {20'h0, a};
   endfunction

   task automatic push_wb(input bit we, input logic [31:0] adr, input logic [31:0] dat);
      wb_exp_t e;
      e.we = we; e.adr = adr; e.dat = dat;
      wbq.push_back(e);
   endtask

   task automatic push_resp(input bit is_rd, input logic [1:0] resp, input logic [31:0] data);
      resp_exp_t e;
      e.is_rd = is_rd; e.resp = resp; e.data = data;
      respq.push_back(e);
   endtask

   // Wishbone slave model: acks after wait_states cycles and checks each access.
   initial begin : wb_slave
      int ws;
      int len;
      wb_exp_t e;
      ws = 0;
      len = 0;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_dat_i = 32'h0;
      forever begin
         @(negedge clk);
         if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
            if (len == 0) wb_cycles++;
            len++;
            if (!wb.wbm_ack_i && ack_en && ws == wait_states) begin
               wb.wbm_ack_i = 1'b1;
               wb.wbm_dat_i = rd_word;
               chk("wb_expected", wbq.size() != 0, 1);
               if (wbq.size() != 0) begin
                  e = wbq.pop_front();
                  chk("wb_we", wb.wbm_we_o, e.we);
                  chk("wb_adr", wb.wbm_adr_o, e.adr);
                  chk("wb_sel", wb.wbm_sel_o, 4'hF);
                  if (e.we) chk("wb_dat", wb.wbm_dat_o, e.dat);
               end
            end else begin
               wb.wbm_ack_i = 1'b0;
            end
            ws++;
         end else begin
            wb.wbm_ack_i = 1'b0;
            ws = 0;
            if (len != 0) last_cyc_len = len;
            len = 0;
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cyc"}, wb.wbm_cyc_o, 0);
      chk({tag, "_stb"}, wb.wbm_stb_o, 0);
      chk({tag, "_we"}, wb.wbm_we_o, 0);
      chk({tag, "_sel"}, wb.wbm_sel_o, 0);
      chk({tag, "_adr"}, wb.wbm_adr_o, 0);
      chk({tag, "_dat_o"}, wb.wbm_dat_o, 0);
      chk({tag, "_bvalid"}, axi.bvalid, 0);
      chk({tag, "_bresp"}, axi.bresp, 0);
      chk({tag, "_rvalid"}, axi.rvalid, 0);
      chk({tag, "_rdata"}, axi.rdata, 0);
      chk({tag, "_rresp"}, axi.rresp, 0);
      chk({tag, "_awready"}, axi.awready, 0);
      chk({tag, "_wready"}, axi.wready, 0);
      chk({tag, "_arready"}, axi.arready, 0);
   endtask

   // W is offered first; AW follows w_lead cycles later. Optionally AR rides along.
   task automatic drive_write(input logic [11:0] a, input logic [31:0] d, input int w_lead,
                              input bit with_ar, input logic [11:0] ar_a);
      int n = 0;
      bit aw_done = 1'b0;
      bit w_done = 1'b0;
      bit aw_fire;
      bit w_fire;
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge clk);
         if (n == 0) begin
            axi.wvalid = 1'b1;
            axi.wdata  = d;
            if (with_ar) begin
               axi.arvalid = 1'b1;
               axi.araddr  = ar_a;
            end
         end
         if (n == w_lead) begin
            axi.awvalid = 1'b1;
            axi.awaddr  = a;
         end
         #1;
         aw_fire = axi.awvalid && axi.awready;
         w_fire  = axi.wvalid && axi.wready;
         if (with_ar) chk("ar_blocked", axi.arready, 0);
         @(posedge clk);
         #1;
         if (aw_fire) begin axi.awvalid = 1'b0; aw_done = 1'b1; end
         if (w_fire)  begin axi.wvalid  = 1'b0; w_done  = 1'b1; end
         if (!aw_done) chk("no_early_cyc", wb.wbm_cyc_o, 0);
         n++;
      end
      chk("wr_hs", aw_done && w_done, 1);
   endtask

   task automatic drive_read(input logic [11:0] a);
      int n = 0;
      bit done = 1'b0;
      bit fire;
      while (!done && n < 50) begin
         @(negedge clk);
         axi.arvalid = 1'b1;
         axi.araddr  = a;
         #1;
         fire = axi.arvalid && axi.arready;
         @(posedge clk);
         #1;
         if (fire) begin axi.arvalid = 1'b0; done = 1'b1; end
         n++;
      end
      chk("rd_hs", done, 1);
   endtask

   task automatic get_b();
      int n = 0;
      resp_exp_t e;
      @(negedge clk);
      while (!axi.bvalid && n < 100) begin @(negedge clk); n++; end
      chk("b_seen", axi.bvalid, 1);
      chk("b_expected", respq.size() != 0, 1);
      if (respq.size() != 0) begin
         e = respq.pop_front();
         chk("b_kind", e.is_rd, 0);
         chk("bresp", axi.bresp, e.resp);
      end
      chk("b_awready_low", axi.awready, 0);
      chk("b_wready_low", axi.wready, 0);
      axi.bready = 1'b1;
      @(posedge clk);
      #1;
      axi.bready = 1'b0;
      chk("b_drop", axi.bvalid, 0);
   endtask

   task automatic get_r(input int hold);
      int n = 0;
      resp_exp_t e;
      @(negedge clk);
      while (!axi.rvalid && n < 100) begin @(negedge clk); n++; end
      chk("r_seen", axi.rvalid, 1);
      chk("r_expected", respq.size() != 0, 1);
      if (respq.size() != 0) begin
         e = respq.pop_front();
         chk("r_kind", e.is_rd, 1);
         chk("rdata", axi.rdata, e.data);
         chk("rresp", axi.rresp, e.resp);
         chk("r_arready_low", axi.arready, 0);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_valid", axi.rvalid, 1);
            chk("r_hold_data", axi.rdata, e.data);
         end
      end
      axi.rready = 1'b1;
      @(posedge clk);
      #1;
      axi.rready = 1'b0;
      chk("r_drop", axi.rvalid, 0);
   endtask

   // Absolute time bound so the run always terminates.
   initial begin : time_guard
      #500000;
      $display("FAIL time_guard: got timeout expected completion");
      $fatal(1, "simulation time bound exceeded");
   end

   initial begin : main
      int c0;
      axi.awvalid = 1'b0; axi.awaddr = 12'h0; axi.wvalid = 1'b0; axi.wdata = 32'h0;
      axi.bready  = 1'b0; axi.arvalid = 1'b0; axi.araddr = 12'h0; axi.rready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_awready", axi.awready, 1);
      chk("idle_arready", axi.arready, 1);

      // 1: AW and W together, ack on the first strobe.
      wait_states = 0;
      push_wb(1'b1, exp_adr(12'h010), 32'h1234_5678);
      push_resp(1'b0, OKAY, 32'h0);
      drive_write(12'h010, 32'h1234_5678, 0, 1'b0, 12'h0);
      chk("t1_cyc", wb.wbm_cyc_o, 1);
      chk("t1_stb", wb.wbm_stb_o, 1);
      chk("t1_we", wb.wbm_we_o, 1);
      chk("t1_adr", wb.wbm_adr_o, 32'h3000_0010);
      chk("t1_dat", wb.wbm_dat_o, 32'h1234_5678);
      chk("t1_bvalid_early", axi.bvalid, 0);
      @(posedge clk);
      #1;
      chk("t1_bvalid_t2", axi.bvalid, 1);
      chk("t1_cyc_drop", wb.wbm_cyc_o, 0);
      get_b();

      // 2: W leads AW by three cycles; exactly one WB write.
      c0 = wb_cycles;
      push_wb(1'b1, exp_adr(12'h084), 32'hCAFE_0002);
      push_resp(1'b0, OKAY, 32'h0);
      drive_write(12'h084, 32'hCAFE_0002, 3, 1'b0, 12'h0);
      get_b();
      chk("t2_one_cycle", wb_cycles - c0, 1);

      // 3: read with three wait states, rready held low for four cycles.
      wait_states = 3;
      rd_word = 32'h0000_0006;
      push_wb(1'b0, exp_adr(12'h000), 32'h0);
      push_resp(1'b1, OKAY, 32'h0000_0006);
      drive_read(12'h000);
      get_r(4);

      // 4: AR alongside AW+W; the write goes first.
      wait_states = 0;
      rd_word = 32'h0000_4545;
      c0 = wb_cycles;
      push_wb(1'b1, exp_adr(12'h040), 32'h0000_4444);
      push_wb(1'b0, exp_adr(12'h044), 32'h0);
      push_resp(1'b0, OKAY, 32'h0);
      push_resp(1'b1, OKAY, 32'h0000_4545);
      drive_write(12'h040, 32'h0000_4444, 0, 1'b1, 12'h044);
      get_b();
      drive_read(12'h044);
      get_r(0);
      chk("t4_two_cycles", wb_cycles - c0, 2);

      // 5: read never acknowledged, then a normal write.
      ack_en = 1'b0;
      push_resp(1'b1, SLVERR, 32'hDEAD_BEEF);
      drive_read(12'h020);
      get_r(0);
      chk("t5_cyc_len", last_cyc_len, 16);
      ack_en = 1'b1;
      wait_states = 1;
      push_wb(1'b1, exp_adr(12'hFFC), 32'h5A5A_A5A5);
      push_resp(1'b0, OKAY, 32'h0);
      drive_write(12'hFFC, 32'h5A5A_A5A5, 1, 1'b0, 12'h0);
      get_b();

      // 5b: ack lands in the same cycle the watchdog expires.
      wait_states = 15;
      rd_word = 32'hA5A5_0F0F;
      push_wb(1'b0, exp_adr(12'h100), 32'h0);
      push_resp(1'b1, OKAY, 32'hA5A5_0F0F);
      drive_read(12'h100);
      get_r(0);
      chk("t5b_cyc_len", last_cyc_len, 16);

      // 6: reset pulse while a write is waiting for ack.
      ack_en = 1'b0;
      wait_states = 0;
      drive_write(12'h200, 32'h6666_6666, 0, 1'b0, 12'h0);
      chk("t6_in_cycle", wb.wbm_cyc_o, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals("t6");
      @(negedge clk);
      rst = 1'b0;
      ack_en = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t6_no_bvalid", axi.bvalid, 0);
      chk("t6_no_cyc", wb.wbm_cyc_o, 0);

      // 7: bridge recovers after the reset.
      rd_word = 32'h0000_0007;
      push_wb(1'b0, exp_adr(12'hFFC), 32'h0);
      push_resp(1'b1, OKAY, 32'h0000_0007);
      drive_read(12'hFFC);
      get_r(1);

      chk("wbq_empty", wbq.size(), 0);
      chk("respq_empty", respq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
